// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types, bus encodings and index helper for the data memory slave
package data_mem_pkg;

    localparam int BUS_W = 32;

`ifdef DATA_MEM_PARITY_EN
    localparam int WORD_W = BUS_W + 1;
`else
    localparam int WORD_W = BUS_W;
`endif

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    // Full word index; callers truncate to their array index width.
    function automatic logic [29:0] word_idx(input logic [BUS_W-1:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - cpu data bus between the load/store path and the data memory
interface data_mem_if;
    import data_mem_pkg::*;

    logic             CS;
    logic             wr_rd;
    logic [BUS_W-1:0] ADDR;
    logic [BUS_W-1:0] Data_BUS_WRITE;
    logic             par_inject;
    logic [BUS_W-1:0] Data_BUS_READ;
    logic             busy;
    logic             addr_err;
    logic             par_err;

    modport master (
        output CS, wr_rd, ADDR, Data_BUS_WRITE, par_inject,
        input  Data_BUS_READ, busy, addr_err, par_err
    );

    modport slave (
        input  CS, wr_rd, ADDR, Data_BUS_WRITE, par_inject,
        output Data_BUS_READ, busy, addr_err, par_err
    );
endinterface

// File: rtl/dm_ram_array.sv
// rtl/dm_ram_array.sv - DEPTH x WIDTH storage, one synchronous write and one synchronous read port, no reset
module dm_ram_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // rdata only moves on a read, so it naturally holds the last value fetched.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_slave.sv
// rtl/data_mem_slave.sv - scrub-on-reset word data memory with address checking
// Optional per-word even parity is built when DATA_MEM_PARITY_EN is defined.
module data_mem_slave
    import data_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = $clog2(DEPTH)
) (
    input  logic    CLK,
    input  logic    reset,
    data_mem_if.slave bus
);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [ADDR_W-1:0]   idx;
    logic                in_range;
    logic                aligned;
    logic                clearing;
    logic                wr_ok;
    logic                rd_ok;
    logic                rd_bad;
    logic                bad;
    logic                out_sel;
    logic                rd_fresh;
    logic                addr_err_q;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [WORD_W-1:0]   ram_wdata;
    logic [WORD_W-1:0]   ram_rdata;

    assign idx      = ADDR_W'(word_idx(bus.ADDR));
    // BASE_ADDR is aligned to the array span, so range reduces to matching the upper bits.
    assign in_range = (bus.ADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign aligned  = (bus.ADDR[1:0] == 2'b00);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        clearing = 1'b0;
        wr_ok    = 1'b0;
        rd_ok    = 1'b0;
        rd_bad   = 1'b0;
        bad      = 1'b0;
        case (state)
            CLEAR: begin
                clearing = 1'b1;
                if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                if (bus.CS) begin
                    if (in_range && aligned) begin
                        wr_ok = (bus.wr_rd == WR);
                        rd_ok = (bus.wr_rd == RD);
                    end else begin
                        bad    = 1'b1;
                        rd_bad = (bus.wr_rd == RD);
                    end
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            clr_ptr    <= '0;
            out_sel    <= 1'b0;
            rd_fresh   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            if (clearing) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            addr_err_q <= bad;
            rd_fresh   <= rd_ok;
            // out_sel=0 forces zero on the bus after reset or a rejected read.
            if (rd_ok) begin
                out_sel <= 1'b1;
            end else if (rd_bad) begin
                out_sel <= 1'b0;
            end
        end
    end

    assign ram_we    = clearing | wr_ok;
    assign ram_waddr = clearing ? clr_ptr : idx;

`ifdef DATA_MEM_PARITY_EN
    assign ram_wdata   = clearing ? '0 : {(^bus.Data_BUS_WRITE) ^ bus.par_inject, bus.Data_BUS_WRITE};
    assign bus.par_err = rd_fresh & ((^ram_rdata[BUS_W-1:0]) != ram_rdata[BUS_W]);
`else
    logic unused_par;
    assign unused_par  = ^{rd_fresh, bus.par_inject};
    assign ram_wdata   = clearing ? '0 : bus.Data_BUS_WRITE;
    assign bus.par_err = 1'b0;
`endif

    dm_ram_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (WORD_W)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_ok),
        .raddr (idx),
        .rdata (ram_rdata)
    );

    assign bus.Data_BUS_READ = out_sel ? ram_rdata[BUS_W-1:0] : '0;
    assign bus.busy          = (state == CLEAR);
    assign bus.addr_err      = addr_err_q;

endmodule

// File: tb/tb_data_mem_slave.sv
// tb/tb_data_mem_slave.sv - directed scoreboard bench for data_mem_slave (DEPTH=16, BASE 0x2000)
module tb_data_mem_slave;

`ifdef DATA_MEM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        ae;
        logic        pe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rsp_due = 1'b0;
    logic rsp_pending = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    data_mem_if bus();

    data_mem_slave #(
        .DEPTH     (16),
        .BASE_ADDR (32'h0000_2000)
    ) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rsp_pending <= rsp_due;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic inj,
                       input logic [31:0] ed, input logic ea, input logic ep);
        exp_t e;
        @(posedge clk);
        #1;
        bus.CS = 1'b1;
        bus.wr_rd = w;
        bus.ADDR = a;
        bus.Data_BUS_WRITE = d;
        bus.par_inject = inj;
        rsp_due = 1'b1;
        e.d = ed;
        e.ae = ea;
        e.pe = ep;
        exp_q.push_back(e);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.CS = 1'b0;
            bus.par_inject = 1'b0;
            rsp_due = 1'b0;
        end
    endtask

    // Counts busy cycles after release; optional CS traffic during the scrub must be ignored.
    task automatic scrub(input string name, input logic cs_during);
        int n;
        bus.CS = cs_during;
        bus.wr_rd = 1'b1;
        bus.ADDR = 32'h0000_2000;
        bus.Data_BUS_WRITE = 32'h0000_0099;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else break;
        end
        bus.CS = 1'b0;
        chk(name, n, 16);
        chk({name, "_rd_zero"}, bus.Data_BUS_READ, 32'h0);
    endtask

    task automatic reset_now(input string name);
        #3;
        rst = 1'b1;
        #1;
        chk({name, "_busy"}, {31'h0, bus.busy}, 32'h1);
        chk({name, "_rd"}, bus.Data_BUS_READ, 32'h0);
        chk({name, "_aerr"}, {31'h0, bus.addr_err}, 32'h0);
        chk({name, "_perr"}, {31'h0, bus.par_err}, 32'h0);
    endtask

    // Monitor: every cycle following an issued access presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_pending) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", bus.Data_BUS_READ, e.d);
                    chk("addr_err", {31'h0, bus.addr_err}, {31'h0, e.ae});
                    chk("par_err", {31'h0, bus.par_err}, {31'h0, e.pe});
                end
            end else if (bus.addr_err || bus.par_err) begin
                chk("spurious_err", {30'h0, bus.addr_err, bus.par_err}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CS = 1'b0;
        bus.wr_rd = 1'b0;
        bus.ADDR = 32'h0;
        bus.Data_BUS_WRITE = 32'h0;
        bus.par_inject = 1'b0;
        #1;
        chk("reset_busy", {31'h0, bus.busy}, 32'h1);
        chk("reset_rd", bus.Data_BUS_READ, 32'h0);
        chk("reset_aerr", {31'h0, bus.addr_err}, 32'h0);
        chk("reset_perr", {31'h0, bus.par_err}, 32'h0);
        repeat (3) @(posedge clk);
        scrub("busy_len_1", 1'b0);

        // Basic read/write and write-then-read ordering.
        acc(1'b0, 32'h2000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        acc(1'b1, 32'h2010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0);
        acc(1'b0, 32'h2010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        acc(1'b1, 32'h2004, 32'h1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        acc(1'b0, 32'h2004, 32'h0, 1'b0, 32'h1, 1'b0, 1'b0);
        acc(1'b1, 32'h2004, 32'h2, 1'b0, 32'h1, 1'b0, 1'b0);
        acc(1'b0, 32'h2004, 32'h0, 1'b0, 32'h2, 1'b0, 1'b0);

        // Address checking and boundaries.
        acc(1'b1, 32'h2000, 32'hA5A5, 1'b0, 32'h2, 1'b0, 1'b0);
        acc(1'b0, 32'h2000, 32'h0, 1'b0, 32'hA5A5, 1'b0, 1'b0);
        acc(1'b0, 32'h2040, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        acc(1'b1, 32'h2002, 32'hFFFF, 1'b0, 32'h0, 1'b1, 1'b0);
        acc(1'b0, 32'h2001, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        acc(1'b0, 32'h1FFC, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        acc(1'b1, 32'h203C, 32'hCAFE, 1'b0, 32'h0, 1'b0, 1'b0);
        acc(1'b0, 32'h203C, 32'h0, 1'b0, 32'hCAFE, 1'b0, 1'b0);
        acc(1'b0, 32'h2000, 32'h0, 1'b0, 32'hA5A5, 1'b0, 1'b0);

        // Parity injection and a clean rewrite.
        acc(1'b1, 32'h200C, 32'h5, 1'b1, 32'hA5A5, 1'b0, 1'b0);
        acc(1'b0, 32'h200C, 32'h0, 1'b0, 32'h5, 1'b0, PAR);
        acc(1'b1, 32'h200C, 32'h7, 1'b0, 32'h5, 1'b0, 1'b0);
        acc(1'b0, 32'h200C, 32'h0, 1'b0, 32'h7, 1'b0, 1'b0);
        gap(3);

        // Reset mid-scrub, then mid-traffic.
        reset_now("rst_idle");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        reset_now("rst_scrub");
        scrub("busy_len_2", 1'b0);
        acc(1'b1, 32'h2008, 32'h1234, 1'b0, 32'h0, 1'b0, 1'b0);
        acc(1'b0, 32'h2008, 32'h0, 1'b0, 32'h1234, 1'b0, 1'b0);
        gap(3);
        reset_now("rst_traffic");
        scrub("busy_len_3", 1'b1);
        acc(1'b0, 32'h2008, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        acc(1'b0, 32'h2000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        gap(4);

        chk("queue_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
